mem_arbiter: RTL

- Sequences the datapath's instruction and data requests onto the single shared RAM port, one at a time.
- Returns ihit/dhit and load data to the datapath.
- Implements the LL/SC reservation (link register) for atomic accesses.
- Sits between the datapath-side cache interface and the RAM model, in place of direct RAM wiring.

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Datapath cache bus plus shared RAM port as seen by mem_arbiter.
// slave = the arbiter, master = the datapath/RAM side driving it.
interface mem_arbiter_if #(parameter int WORD_W = 32);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic [WORD_W-1:0] iload;
    logic              ihit;
    logic              dREN;
    logic              dWEN;
    logic              datomic;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic [WORD_W-1:0] dload;
    logic              dhit;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              ram_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
    modport master (
        output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction/data requests onto one RAM port and owns the LL/SC link register.
// Optional ARB_STARVE_GUARD_EN: bounds data grants while an instruction fetch waits.
module mem_arbiter #(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT, SCFAIL} state_e;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_e              state_q, state_d;
    logic                link_valid_q, link_valid_d;
    logic [WORD_W-3:0]   link_addr_q, link_addr_d;
    logic                ram_err_q, ram_err_d;
    logic                dreq, sc_ok, force_i;

    assign dreq  = bus.dREN | bus.dWEN;
    assign sc_ok = link_valid_q && (link_addr_q == bus.daddr[WORD_W-1:2]);
    assign bus.ram_err = ram_err_q;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_q, starve_d;

    assign force_i = bus.iREN && (starve_q == CW'(STARVE_LIMIT));

    // Counts data grants taken while a fetch is waiting; any fetch grant clears it.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (state_d == IGRANT)
                starve_d = '0;
            else if (state_d == DGRANT || state_d == SCFAIL)
                starve_d = bus.iREN ? starve_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign force_i = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        ram_err_d    = ram_err_q;
        bus.iload    = '0;
        bus.ihit     = 1'b0;
        bus.dload    = '0;
        bus.dhit     = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        unique case (state_q)
            IDLE: begin
                // A failing SC is resolved here so the RAM never sees it.
                if (dreq && !force_i)
                    state_d = (bus.dWEN && bus.datomic && !sc_ok) ? SCFAIL : DGRANT;
                else if (bus.iREN)
                    state_d = IGRANT;
            end
            IGRANT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = 1'b1;
                if (bus.ramstate == RAM_ERROR) ram_err_d = 1'b1;
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    bus.ihit  = 1'b1;
                    bus.iload = bus.ramload;
                    state_d   = IDLE;
                end
            end
            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramstore = bus.dstore;
                if (bus.ramstate == RAM_ERROR) ram_err_d = 1'b1;
                if (!dreq) begin
                    state_d = IDLE;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    bus.dhit = 1'b1;
                    state_d  = IDLE;
                    if (bus.dWEN) begin
                        bus.dload = bus.datomic ? WORD_W'(1) : bus.ramload;
                        if (bus.datomic || bus.daddr[WORD_W-1:2] == link_addr_q)
                            link_valid_d = 1'b0;
                    end else begin
                        bus.dload = bus.ramload;
                        if (bus.datomic) begin
                            link_valid_d = 1'b1;
                            link_addr_d  = bus.daddr[WORD_W-1:2];
                        end
                    end
                end
            end
            SCFAIL: begin
                bus.dhit     = 1'b1;
                link_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            ram_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            ram_err_q    <= ram_err_d;
        end
    end
endmodule
